// File: rtl/axi_pkg.sv
// Shared AXI subordinate types: response codes and write-path FSM states.
// Also imported by the read-path controller.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_sub_write_ctrl.sv
// Single-outstanding AXI4-Lite style write subordinate: takes AW and W in either
// order, captures them, and returns one B response per transaction.
module axi_sub_write_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic                  en_aw,
  input  logic                  en_w,
  input  logic                  en_b,
  input  logic [1:0]            bresp_in,
  output logic [ADDR_W-1:0]     rx_aw,
  output logic [DATA_W-1:0]     rx_w,
  output logic [DATA_W/8-1:0]   rx_wstrb,
  output logic                  new_aw,
  output logic                  new_w,
  output logic                  new_b,
  output logic [15:0]           wr_count
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  wr_state_t           state_q, state_d;
  resp_t               resp_q, resp_d;
  logic                bvalid_q, bvalid_d;
  logic [ADDR_W-1:0]   rx_aw_q, rx_aw_d;
  logic [DATA_W-1:0]   rx_w_q, rx_w_d;
  logic [STRB_W-1:0]   rx_wstrb_q, rx_wstrb_d;
  logic                new_aw_q, new_aw_d;
  logic                new_w_q, new_w_d;
  logic                new_b_q, new_b_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic                aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0]   addr_eff;
  logic [STRB_W-1:0]   strb_eff;
  logic                bad_req;

  assign AWREADY = en_aw & ((state_q == IDLE) | (state_q == HAVE_W));
  assign WREADY  = en_w  & ((state_q == IDLE) | (state_q == HAVE_AW));

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = bvalid_q & BREADY;

  // The error check must see a channel captured in this same cycle, so use the
  // live input when its handshake is happening, else the held copy.
  assign addr_eff = aw_hs ? AWADDR : rx_aw_q;
  assign strb_eff = w_hs  ? WSTRB  : rx_wstrb_q;
  assign bad_req  = (|(addr_eff & ALIGN_MASK)) | (strb_eff == '0);

  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    rx_aw_d    = aw_hs ? AWADDR : rx_aw_q;
    rx_w_d     = w_hs  ? WDATA  : rx_w_q;
    rx_wstrb_d = w_hs  ? WSTRB  : rx_wstrb_q;
    new_aw_d   = aw_hs;
    new_w_d    = w_hs;
    new_b_d    = b_hs;
    wr_count_d = b_hs ? wr_count_q + 16'd1 : wr_count_q;

    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = RESP;
        else if (aw_hs)    state_d = HAVE_AW;
        else if (w_hs)     state_d = HAVE_W;
      end
      HAVE_AW: if (w_hs)  state_d = RESP;
      HAVE_W:  if (aw_hs) state_d = RESP;
      RESP:    if (b_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q != RESP) && (state_d == RESP)) begin
      resp_d = bad_req ? SLVERR : resp_t'(bresp_in);
    end else if (b_hs) begin
      resp_d = OKAY;
    end

    // Once raised, BVALID ignores en_b until the handshake retires it.
    bvalid_d = (state_d == RESP) & (en_b | bvalid_q);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      resp_q     <= OKAY;
      bvalid_q   <= 1'b0;
      rx_aw_q    <= '0;
      rx_w_q     <= '0;
      rx_wstrb_q <= '0;
      new_aw_q   <= 1'b0;
      new_w_q    <= 1'b0;
      new_b_q    <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      bvalid_q   <= bvalid_d;
      rx_aw_q    <= rx_aw_d;
      rx_w_q     <= rx_w_d;
      rx_wstrb_q <= rx_wstrb_d;
      new_aw_q   <= new_aw_d;
      new_w_q    <= new_w_d;
      new_b_q    <= new_b_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign BRESP    = resp_q;
  assign BVALID   = bvalid_q;
  assign rx_aw    = rx_aw_q;
  assign rx_w     = rx_w_q;
  assign rx_wstrb = rx_wstrb_q;
  assign new_aw   = new_aw_q;
  assign new_w    = new_w_q;
  assign new_b    = new_b_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_axi_sub_write_ctrl.sv
// Directed bench for axi_sub_write_ctrl: hand-computed expectations checked
// with immediate assertions one cycle at a time.
module tb_axi_sub_write_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        en_aw, en_w, en_b;
  logic [1:0]  bresp_in;
  logic [31:0] rx_aw;
  logic [63:0] rx_w;
  logic [7:0]  rx_wstrb;
  logic        new_aw, new_w, new_b;
  logic [15:0] wr_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 ACLK = ~ACLK;

  axi_sub_write_ctrl #(.ADDR_W(32), .DATA_W(64)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .en_aw(en_aw), .en_w(en_w), .en_b(en_b), .bresp_in(bresp_in),
    .rx_aw(rx_aw), .rx_w(rx_w), .rx_wstrb(rx_wstrb),
    .new_aw(new_aw), .new_w(new_w), .new_b(new_b), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
    WVALID = 1'b0; BREADY = 1'b0; en_aw = 1'b1; en_w = 1'b1; en_b = 1'b1;
    bresp_in = 2'b00;
    #12;
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 1);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rx_aw", rx_aw, 0);
    ARESETn = 1'b1;
    tick();

    // AW and W together
    AWADDR = 32'h1000; AWVALID = 1'b1;
    WDATA = 64'hDEADBEEF_CAFEF00D; WSTRB = 8'hFF; WVALID = 1'b1;
    BREADY = 1'b1; bresp_in = 2'b00;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_rx_aw", rx_aw, 64'h1000);
    chk("t1_rx_w", rx_w, 64'hDEADBEEF_CAFEF00D);
    chk("t1_rx_wstrb", rx_wstrb, 8'hFF);
    chk("t1_new_aw", new_aw, 1);
    chk("t1_new_w", new_w, 1);
    chk("t1_bvalid", BVALID, 1);
    chk("t1_bresp", BRESP, 0);
    chk("t1_awready_resp", AWREADY, 0);
    tick();
    chk("t1_new_b", new_b, 1);
    chk("t1_wr_count", wr_count, 1);
    chk("t1_bvalid_off", BVALID, 0);
    chk("t1_new_aw_off", new_aw, 0);

    // W three cycles before AW, BREADY held low
    BREADY = 1'b0; bresp_in = 2'b01;
    WDATA = 64'h1111_2222_3333_4444; WSTRB = 8'h0F; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("t2_wready_drop", WREADY, 0);
    chk("t2_awready_hi", AWREADY, 1);
    chk("t2_new_w", new_w, 1);
    chk("t2_bvalid_wait", BVALID, 0);
    tick();
    tick();
    AWADDR = 32'h2008; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t2_bvalid", BVALID, 1);
    chk("t2_bresp", BRESP, 2'b01);
    chk("t2_rx_aw", rx_aw, 64'h2008);
    chk("t2_rx_wstrb", rx_wstrb, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_bvalid_hold", BVALID, 1);
      chk("t2_bresp_hold", BRESP, 2'b01);
    end
    BREADY = 1'b1;
    tick();
    chk("t2_new_b", new_b, 1);
    chk("t2_wr_count", wr_count, 2);
    chk("t2_bvalid_off", BVALID, 0);
    tick();
    chk("t2_one_b", wr_count, 2);
    chk("t2_new_b_off", new_b, 0);

    // Misaligned address
    bresp_in = 2'b00;
    AWADDR = 32'h1004; AWVALID = 1'b1; WSTRB = 8'hFF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t3_misalign_bresp", BRESP, 2'b10);
    tick();
    chk("t3_wr_count", wr_count, 3);
    chk("t3_bresp_idle", BRESP, 0);
    // Aligned, zero strobes
    AWADDR = 32'h3000; AWVALID = 1'b1; WSTRB = 8'h00; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t3_zero_strb_bresp", BRESP, 2'b10);
    tick();
    // Aligned, good strobes, DECERR passes through
    bresp_in = 2'b11;
    AWADDR = 32'h3008; AWVALID = 1'b1; WSTRB = 8'h01; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t3_decerr_bresp", BRESP, 2'b11);
    tick();
    chk("t3_wr_count5", wr_count, 5);

    // en_b low after both handshakes
    bresp_in = 2'b00; en_b = 1'b0; BREADY = 1'b0;
    AWADDR = 32'h5000; AWVALID = 1'b1; WSTRB = 8'hFF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_gated", BVALID, 0);
      tick();
    end
    en_b = 1'b1;
    tick();
    chk("t4_bvalid_rise", BVALID, 1);
    en_b = 1'b0;
    tick();
    chk("t4_bvalid_hold_enb", BVALID, 1);
    BREADY = 1'b1;
    tick();
    chk("t4_wr_count", wr_count, 6);
    chk("t4_bvalid_off", BVALID, 0);
    en_b = 1'b1;

    // Counter wrap
    force dut.wr_count_q = 16'hFFFF;
    tick();
    release dut.wr_count_q;
    chk("t5_preload", wr_count, 16'hFFFF);
    AWADDR = 32'h6000; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t5_bvalid", BVALID, 1);
    tick();
    chk("t5_wrap", wr_count, 0);

    // Reset while holding only the address
    AWADDR = 32'h4000; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t6_have_aw_awready", AWREADY, 0);
    chk("t6_have_aw_wready", WREADY, 1);
    chk("t6_rx_aw", rx_aw, 64'h4000);
    #1 ARESETn = 1'b0;
    #1;
    chk("t6_rst_rx_aw", rx_aw, 0);
    chk("t6_rst_rx_w", rx_w, 0);
    chk("t6_rst_new_aw", new_aw, 0);
    chk("t6_rst_wr_count", wr_count, 0);
    chk("t6_rst_awready", AWREADY, 1);
    chk("t6_rst_wready", WREADY, 1);
    chk("t6_rst_bvalid", BVALID, 0);
    ARESETn = 1'b1;
    tick();
    WDATA = 64'h0123_4567_89AB_CDEF; WSTRB = 8'hF0; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("t6_have_w_wready", WREADY, 0);
    chk("t6_have_w_awready", AWREADY, 1);
    chk("t6_have_w_bvalid", BVALID, 0);
    tick();
    chk("t6_still_no_b", BVALID, 0);
    AWADDR = 32'h7000; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("t6_finish_bvalid", BVALID, 1);
    tick();
    chk("t6_wr_count", wr_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_sub_write_ctrl.md
# axi_sub_write_ctrl

Subordinate-side AXI write-path controller: accepts the AW and W channels from a manager in either order, completes each transaction with a single B response, and presents the captured address and data to the testbench control interface. It sits directly downstream of the manager's AW/W/B ports. On the testbench side it consumes the channel enables and the response to send, and produces the received-value and new-data indications. Transactions are single-beat, AXI4-Lite style, with one outstanding write.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width (multiple of 8); STRB_W = DATA_W/8 is derived
- ACLK  in  1  clock; all logic is on the rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWADDR  in  ADDR_W  write address
- AWVALID / AWREADY  in / out  1  AW handshake
- WDATA  in  DATA_W  write data
- WSTRB  in  STRB_W  byte strobes
- WVALID / WREADY  in / out  1  W handshake
- BRESP  out  2  write response
- BVALID / BREADY  out / in  1  B handshake
- en_aw, en_w, en_b  in  1 each  testbench channel enables (tx_en[4], tx_en[3], tx_en[2])
- bresp_in  in  2  response the testbench wants returned
- rx_aw  out  ADDR_W  last captured address
- rx_w  out  DATA_W  last captured data
- rx_wstrb  out  STRB_W  last captured strobes
- new_aw, new_w, new_b  out  1 each  one-cycle flags (new_data[4], [3], [2])
- wr_count  out  16  count of completed B handshakes

## Operation
- FSM states:
  - IDLE: neither channel has been captured yet.
  - HAVE_AW: address captured, data pending.
  - HAVE_W: data captured, address pending.
  - RESP: response pending.
- AWREADY = en_aw & (IDLE | HAVE_W). WREADY = en_w & (IDLE | HAVE_AW). Both are combinational from state and enable.
- Transitions:
  - IDLE: both handshakes in the same cycle go to RESP; AW only goes to HAVE_AW; W only goes to HAVE_W.
  - HAVE_AW: W handshake goes to RESP.
  - HAVE_W: AW handshake goes to RESP.
  - RESP: BVALID & BREADY goes to IDLE.
- Capture:
  - An AW handshake loads rx_aw.
  - A W handshake loads rx_w and rx_wstrb.
  - Captured values hold until the next handshake on that channel.
- Response selection, latched on entry to RESP:
  - SLVERR (2'b10) if the address is misaligned (AWADDR[log2(STRB_W)-1:0] != 0) or WSTRB == 0.
  - Otherwise bresp_in.
- BVALID = (state == RESP) & en_b, registered. When en_b is low in RESP, BVALID is held low and the FSM waits.
- BRESP is stable while BVALID is high. It reads 2'b00 outside RESP.
- wr_count increments by 1 on each B handshake and wraps from 0xFFFF to 0.

## Timing
- Reset values: AWREADY and WREADY follow the combinational rule with state = IDLE (they equal the enables). All other outputs are 0: BVALID, BRESP, rx_aw, rx_w, rx_wstrb, new_*, wr_count. State = IDLE.
- new_aw and new_w pulse high for exactly one cycle, in the cycle after the respective handshake edge.
- new_b pulses one cycle after the B handshake edge.
- BVALID rises in the cycle after the later of the AW/W handshakes, given en_b is high. Minimum latency from the last handshake to B is 1 cycle.
- Once BVALID is high, it holds until BREADY is sampled high, even if en_b drops.
- A B handshake and a new AW/W handshake cannot share a cycle, because READY is low in RESP. The earliest next AW/W acceptance is the cycle after the B handshake.
- Deasserting VALID before READY violates AXI rules; behaviour in that case is unspecified.
- ARESETn asserted mid-transaction forces all state and outputs to their reset values immediately. A partially captured transaction is discarded.

## Structure
- Shared package axi_pkg holds:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - wr_state_t enum: IDLE, HAVE_AW, HAVE_W, RESP.
- Single module with no sub-modules. The later read-path block, axi_sub_read_ctrl, reuses axi_pkg.

## Test plan
- AW and W in the same cycle: AWADDR = 0x1000, WDATA = 0xDEADBEEF_CAFEF00D, WSTRB = 0xFF, bresp_in = OKAY, BREADY = 1.
  - rx_aw and rx_w update; new_aw and new_w pulse; BVALID is high the next cycle with BRESP = 00; wr_count = 1; new_b pulses.
- W 3 cycles before AW, with BREADY held low for 4 cycles.
  - WREADY drops after the W handshake; AWREADY stays high.
  - BVALID is stable and BRESP is unchanged throughout the wait.
  - Exactly one B handshake occurs.
- Misaligned AWADDR = 0x1004 with bresp_in = OKAY: BRESP = SLVERR. Repeat with an aligned address and WSTRB = 0: BRESP = SLVERR.
- en_b = 0 after both handshakes: BVALID stays 0 for 5 cycles. After en_b rises, BVALID goes high in the next cycle.
- Preload wr_count to 0xFFFF via 65535 writes (or force): the next write gives wr_count = 0.
- ARESETn pulsed low while in HAVE_AW:
  - All outputs return to reset values and state is IDLE.
  - A following W-only handshake leads to HAVE_W, not RESP.
